// File: rtl/approx_mac_pkg.sv
// Shared types and constants for the approximate Wallace-tree MAC.
package approx_mac_pkg;
  localparam int BEAT_W = 16;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} mac_state_e;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction
endpackage

// File: rtl/approx_wallace_reducer.sv
// Partial-product generation and Wallace reduction to sum/carry rows.
// Columns below APPROX_COLS are OR-compressed and never emit a carry.
module one_bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module one_bit_half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b;
  assign cout = a & b;
endmodule

module approx_wallace_reducer
  import approx_mac_pkg::*;
#(
  parameter int W           = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  output logic [prod_w(W)-1:0]  sum_row,
  output logic [prod_w(W)-1:0]  carry_row
);
  localparam int PW   = prod_w(W);
  localparam int HMAX = W + 2;

  // Column heights after s reduction stages; c < 0 returns the tallest column.
  // Column PW is a sink for carries out of the top column and is never reduced.
  function automatic int hinfo(input int s, input int c);
    int h  [0:33];
    int nh [0:33];
    int mx;
    if (c > PW) return 0;
    for (int k = 0; k <= 33; k++) h[k] = 0;
    for (int k = APPROX_COLS; k < PW; k++)
      for (int i = 0; i < W; i++)
        if (k - i >= 0 && k - i < W) h[k] = h[k] + 1;
    for (int st = 0; st < s; st++) begin
      for (int k = 0; k <= 33; k++) nh[k] = 0;
      for (int k = 0; k < PW; k++) begin
        nh[k]   = nh[k]   + h[k] / 3 + ((h[k] % 3 != 0) ? 1 : 0);
        nh[k+1] = nh[k+1] + h[k] / 3 + ((h[k] % 3 == 2) ? 1 : 0);
      end
      for (int k = 0; k <= 33; k++) h[k] = nh[k];
    end
    if (c >= 0) return h[c];
    mx = 0;
    for (int k = 0; k < PW; k++) if (h[k] > mx) mx = h[k];
    return mx;
  endfunction

  function automatic int num_stages();
    int s;
    s = 0;
    while (s < 16 && hinfo(s, -1) > 2) s++;
    return s;
  endfunction

  localparam int NS = num_stages();

  logic m [0:NS][0:PW][0:HMAX-1];
  logic [PW-1:0] or_row;

  for (genvar c = 0; c <= PW; c++) begin : g_init
    localparam int LO = (c > W - 1) ? c - W + 1 : 0;
    for (genvar r = 0; r < HMAX; r++) begin : g_row
      if (r < hinfo(0, c)) begin : g_pp
        assign m[0][c][r] = a[LO+r] & b[c-LO-r];
      end else begin : g_z
        assign m[0][c][r] = 1'b0;
      end
    end
  end

  // Each stage: 3 bits -> FA, leftover 2 -> HA, leftover 1 passes.
  // Next column layout is [own sums/pass | carries from column c-1 | zeros].
  for (genvar s = 0; s < NS; s++) begin : g_stg
    for (genvar c = 0; c <= PW; c++) begin : g_col
      localparam int H    = hinfo(s, c);
      localparam int NFA  = H / 3;
      localparam int NHA  = (H % 3 == 2) ? 1 : 0;
      localparam int PASS = (H % 3 == 1) ? 1 : 0;
      localparam int HN   = hinfo(s + 1, c);
      localparam int H1   = hinfo(s, c + 1);
      localparam int CB   = (c + 1 >= PW) ? 0 : H1 / 3 + ((H1 % 3 != 0) ? 1 : 0);
      if (c < PW) begin : g_red
        for (genvar f = 0; f < NFA; f++) begin : g_fa
          one_bit_full_adder u_fa (
            .a   (m[s][c][3*f]),
            .b   (m[s][c][3*f+1]),
            .cin (m[s][c][3*f+2]),
            .sum (m[s+1][c][f]),
            .cout(m[s+1][c+1][CB+f])
          );
        end
        if (NHA != 0) begin : g_ha
          one_bit_half_adder u_ha (
            .a   (m[s][c][3*NFA]),
            .b   (m[s][c][3*NFA+1]),
            .sum (m[s+1][c][NFA]),
            .cout(m[s+1][c+1][CB+NFA])
          );
        end
        if (PASS != 0) begin : g_pass
          assign m[s+1][c][NFA] = m[s][c][3*NFA];
        end
      end
      for (genvar r = HN; r < HMAX; r++) begin : g_zero
        assign m[s+1][c][r] = 1'b0;
      end
    end
  end

  always_comb begin
    or_row = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (i + j < APPROX_COLS) or_row[i+j] = or_row[i+j] | (a[i] & b[j]);
  end

  // Approximated columns hold zero in the tree, so OR-ing them in is exact.
  for (genvar c = 0; c < PW; c++) begin : g_out
    assign sum_row[c]   = m[NS][c][0] | or_row[c];
    assign carry_row[c] = m[NS][c][1];
  end
endmodule

// File: rtl/approx_wallace_mac.sv
// Pipelined approximate multiply-accumulate with per-frame result handshake.
// Optional macro ACC_SATURATE_EN: clamp the accumulator on overflow instead of wrapping.
module approx_wallace_mac
  import approx_mac_pkg::*;
#(
  parameter int W           = 8,
  parameter int APPROX_COLS = 4,
  parameter int ACC_W       = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_a,
  input  logic [W-1:0]      in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [BEAT_W-1:0] out_beats,
  output logic              out_ovf
);
  localparam int PW     = prod_w(W);
  localparam int STAGES = 2;

  mac_state_e        state, state_nxt;
  logic              adv;
  logic [STAGES:0]   vld_pipe, last_pipe;
  logic [W-1:0]      s1_a, s1_b;
  logic [PW-1:0]     red_sum, red_cy, s2_sum, s2_cy, s3_prod;
  logic [ACC_W:0]    sum_ext;
  logic [ACC_W-1:0]  acc, acc_nxt, acc_add, res_acc_nxt;
  logic [BEAT_W-1:0] cnt, cnt_nxt, cnt_inc, res_beats_nxt;
  logic              flag, flag_nxt, res_ovf_nxt, carry;

  assign out_valid = (state == HOLD);
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  approx_wallace_reducer #(.W(W), .APPROX_COLS(APPROX_COLS)) u_red (
    .a        (s1_a),
    .b        (s1_b),
    .sum_row  (red_sum),
    .carry_row(red_cy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_sum    <= '0;
      s2_cy     <= '0;
      s3_prod   <= '0;
    end else if (adv) begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], in_valid};
      last_pipe <= {last_pipe[STAGES-1:0], in_valid & in_last};
      s1_a      <= in_a;
      s1_b      <= in_b;
      s2_sum    <= red_sum;
      s2_cy     <= red_cy;
      s3_prod   <= s2_sum + s2_cy;
    end
  end

  assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - PW){1'b0}}, s3_prod};
  assign carry   = sum_ext[ACC_W];
`ifdef ACC_SATURATE_EN
  assign acc_add = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_add = sum_ext[ACC_W-1:0];
`endif
  assign cnt_inc = (cnt == {BEAT_W{1'b1}}) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    flag_nxt      = flag;
    res_acc_nxt   = out_acc;
    res_beats_nxt = out_beats;
    res_ovf_nxt   = out_ovf;
    if (state == HOLD && out_ready) state_nxt = ACCUM;
    // A closing beat overrides the HOLD release, reloading the result in place.
    if (adv && vld_pipe[STAGES]) begin
      if (last_pipe[STAGES]) begin
        res_acc_nxt   = acc_add;
        res_beats_nxt = cnt_inc;
        res_ovf_nxt   = flag | carry;
        acc_nxt       = '0;
        cnt_nxt       = '0;
        flag_nxt      = 1'b0;
        state_nxt     = HOLD;
      end else begin
        acc_nxt  = acc_add;
        cnt_nxt  = cnt_inc;
        flag_nxt = flag | carry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      flag      <= 1'b0;
      out_acc   <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      flag      <= flag_nxt;
      out_acc   <= res_acc_nxt;
      out_beats <= res_beats_nxt;
      out_ovf   <= res_ovf_nxt;
    end
  end
endmodule
